// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1-to-4 demux scheduler.
package demux_sched_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam logic [CH_W-1:0]   DEF_SEL   = '0;
  localparam logic [NUM_CH-1:0] DEF_MASK  = '1;
  localparam int unsigned       DEF_BURST = 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    APPLY
  } state_t;

endpackage

// File: rtl/demux_rr_pick.sv
// Masked rotate-priority picker: first enabled channel at or after ptr.
module demux_rr_pick
  import demux_sched_pkg::*;
(
  input  logic [CH_W-1:0]   ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   target,
  output logic              found
);

  always_comb begin
    logic [CH_W-1:0] idx;
    idx    = '0;
    target = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (!found && mask[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Stream scheduler feeding the 1-to-4 demux: one-entry output slot,
// fixed or round-robin channel choice, config applied after a drain.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic [3:0]         out_ready,
  output logic [3:0]         out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               enable,
  output logic [1:0]         sig,
  input  logic               cfg_load,
  input  logic               cfg_mode,
  input  logic [1:0]         cfg_sel,
  input  logic [3:0]         cfg_mask,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               busy,
  output logic               cfg_err
);

  state_t              state;
  logic                full;
  logic [CH_W-1:0]     chan;
  logic [DATA_W-1:0]   data;
  logic [CH_W-1:0]     ptr;
  logic [BURST_W-1:0]  burst_cnt;
  logic                act_mode;
  logic [CH_W-1:0]     act_sel;
  logic [NUM_CH-1:0]   act_mask;
  logic [BURST_W-1:0]  act_burst;
  logic                err_q;

  logic [CH_W-1:0]     rr_target;
  logic                rr_found;
  logic [CH_W-1:0]     target;
  logic                found;
  logic                drain;
  logic                accept;
  logic [BURST_W-1:0]  burst_lim;
  logic [BURST_W:0]    cnt_next;
  logic                last_beat;

  demux_rr_pick u_pick (
    .ptr    (ptr),
    .mask   (act_mask),
    .target (rr_target),
    .found  (rr_found)
  );

  always_comb begin
    target = act_sel;
    found  = 1'b1;
    if (act_mode == MODE_RR) begin
      target = rr_target;
      found  = rr_found;
    end
  end

  assign drain     = full & out_ready[chan];
  assign in_ready  = rst_n & (state == RUN) & found & (~full | out_ready[chan]);
  assign accept    = in_valid & in_ready;
  // A configured burst of 0 dwells like a burst of 1.
  assign burst_lim = (act_burst == '0) ? BURST_W'(1) : act_burst;
  assign cnt_next  = {1'b0, burst_cnt} + {{BURST_W{1'b0}}, 1'b1};
  assign last_beat = cnt_next >= {1'b0, burst_lim};

  assign out_valid = full ? (NUM_CH'(1) << chan) : '0;
  assign out_data  = data;
  assign enable    = full;
  assign sig       = chan;
  assign busy      = full | (state != RUN);
  assign cfg_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      full      <= 1'b0;
      chan      <= '0;
      data      <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      act_mode  <= MODE_FIXED;
      act_sel   <= DEF_SEL;
      act_mask  <= DEF_MASK;
      act_burst <= BURST_W'(DEF_BURST);
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        chan <= target;
        data <= in_data;
      end else if (drain) begin
        full <= 1'b0;
      end

      if (accept && act_mode == MODE_RR) begin
        if (last_beat) begin
          burst_cnt <= '0;
          ptr       <= target + CH_W'(1);
        end else begin
          burst_cnt <= cnt_next[BURST_W-1:0];
        end
      end

      unique case (state)
        RUN: if (cfg_load) state <= DRAIN;
        DRAIN: if (!full || drain) state <= APPLY;
        APPLY: begin
          act_mode  <= cfg_mode;
          act_sel   <= cfg_sel;
          act_mask  <= cfg_mask;
          act_burst <= cfg_burst;
          ptr       <= '0;
          burst_cnt <= '0;
          err_q     <= (cfg_mode == MODE_RR) && (cfg_mask == '0);
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: scenario tasks plus a randomized run, all
// checked against a cycle-level reference model of the scheduling rules.
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] in_data = '0;
  logic       in_ready;
  logic [3:0] out_ready = '0;
  logic [3:0] out_valid;
  logic [0:0] out_data;
  logic       enable;
  logic [1:0] sig;
  logic       cfg_load = 1'b0;
  logic       cfg_mode = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [3:0] cfg_mask = '0;
  logic [3:0] cfg_burst = '0;
  logic       busy;
  logic       cfg_err;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0=run, 1=waiting for empty slot, 2=applying config.
  int m_full = 0, m_chan = 0, m_data = 0, m_ptr = 0, m_cnt = 0, m_phase = 0;
  int m_mode = 0, m_sel = 0, m_mask = 15, m_burst = 1, m_err = 0;

  demux_rr_sched #(.DATA_W(1), .BURST_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .enable    (enable),
    .sig       (sig),
    .cfg_load  (cfg_load),
    .cfg_mode  (cfg_mode),
    .cfg_sel   (cfg_sel),
    .cfg_mask  (cfg_mask),
    .cfg_burst (cfg_burst),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic int m_target();
    if (m_mode == 0) return m_sel;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (((m_mask >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic bit m_inready();
    return rst_n && m_phase == 0 && m_target() >= 0 &&
           (m_full == 0 || out_ready[m_chan] == 1'b1);
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [3:0] ov;
    ov = (m_full != 0) ? 4'(1 << m_chan) : 4'b0000;
    return {logic'(m_inready()), logic'(m_full != 0 || m_phase != 0),
            logic'(m_err != 0), logic'(m_full != 0), 2'(m_chan), ov, 1'(m_data)};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {in_ready, busy, cfg_err, enable, sig, out_valid, out_data};
  endfunction

  task automatic model_edge();
    int tgt, b;
    bit acc, drn;
    if (!rst_n) begin
      m_full = 0; m_chan = 0; m_data = 0; m_ptr = 0; m_cnt = 0; m_phase = 0;
      m_mode = 0; m_sel = 0; m_mask = 15; m_burst = 1; m_err = 0;
      return;
    end
    tgt = m_target();
    acc = in_valid && m_inready();
    drn = m_full != 0 && out_ready[m_chan] == 1'b1;
    case (m_phase)
      0: if (cfg_load) m_phase = 1;
      1: if (m_full == 0 || drn) m_phase = 2;
      default: begin
        m_mode = cfg_mode; m_sel = cfg_sel; m_mask = cfg_mask; m_burst = cfg_burst;
        m_ptr = 0; m_cnt = 0;
        m_err = (cfg_mode == 1'b1 && cfg_mask == 4'b0000) ? 1 : 0;
        m_phase = 0;
      end
    endcase
    if (acc) begin
      m_full = 1; m_chan = tgt; m_data = in_data;
      if (m_mode == 1) begin
        b = (m_burst == 0) ? 1 : m_burst;
        m_cnt++;
        if (m_cnt >= b) begin
          m_cnt = 0;
          m_ptr = (tgt + 1) % 4;
        end
      end
    end else if (drn) begin
      m_full = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic mode, input logic [1:0] sel,
                        input logic [3:0] mask, input logic [3:0] burst);
    int n;
    cfg_mode = mode; cfg_sel = sel; cfg_mask = mask; cfg_burst = burst;
    cfg_load = 1'b1; in_valid = 1'b0; out_ready = 4'hf;
    #1;
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL cfg_issue got=%b exp=%b", obs_vec(), exp_vec());
    end
    tick();
    cfg_load = 1'b0;
    n = 0;
    while (m_phase != 0 && n < 20) begin
      #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL cfg_wait%0d got=%b exp=%b", n, obs_vec(), exp_vec());
      end
      tick();
      n++;
    end
    if (m_phase != 0) begin
      fails++;
      $display("FAIL cfg_timeout got=phase%0d exp=phase0", m_phase);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 4'hf;
    @(negedge clk);
    tick();
    tick();
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || in_ready !== 1'b0 || out_valid !== 4'b0000) begin
      fails++;
      $display("FAIL reset_hold got=%b exp=%b", obs_vec(), exp_vec());
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || enable !== 1'b0 || sig !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got=%b exp=%b", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_fixed();
    logic [0:0] pat [3];
    pat = '{1'b1, 1'b0, 1'b1};
    in_valid = 1'b1; out_ready = 4'hf;
    for (int i = 0; i < 3; i++) begin
      in_data = pat[i];
      tick();
      #1;
      tests++;
      if (obs_vec() !== exp_vec() || out_valid !== 4'b0001 || sig !== 2'd0 ||
          enable !== 1'b1 || out_data !== pat[i]) begin
        fails++;
        $display("FAIL fixed_beat%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rr_burst2();
    int exp_s [10];
    exp_s = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    do_cfg(1'b1, 2'd0, 4'b1111, 4'd2);
    in_valid = 1'b1; out_ready = 4'hf;
    for (int i = 0; i < 10; i++) begin
      in_data = 1'($urandom);
      #1;
      tests++;
      if (obs_vec() !== exp_vec() || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL rr2_pre%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
      tests++;
      if (sig !== 2'(exp_s[i]) || enable !== 1'b1) begin
        fails++;
        $display("FAIL rr2_sig%0d got=%0d exp=%0d", i, sig, exp_s[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rr_mask();
    int exp_s [4];
    exp_s = '{1, 3, 1, 3};
    do_cfg(1'b1, 2'd0, 4'b1010, 4'd1);
    in_valid = 1'b1; out_ready = 4'hf;
    for (int i = 0; i < 4; i++) begin
      in_data = 1'($urandom);
      tick();
      #1;
      tests++;
      if (obs_vec() !== exp_vec() || sig !== 2'(exp_s[i]) ||
          out_valid[0] !== 1'b0 || out_valid[2] !== 1'b0) begin
        fails++;
        $display("FAIL rrmask_beat%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_cfg(1'b0, 2'd1, 4'b1111, 4'd1);
    in_valid = 1'b1; in_data = 1'b1; out_ready = 4'b0000;
    tick();
    in_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (obs_vec() !== exp_vec() || in_ready !== 1'b0 || out_valid !== 4'b0010 ||
          out_data !== 1'b1 || sig !== 2'd1) begin
        fails++;
        $display("FAIL stall%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    out_ready = 4'b0010;
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release got=%b exp=%b", obs_vec(), exp_vec());
    end
    tick();
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || out_valid !== 4'b0010 || out_data !== 1'b0) begin
      fails++;
      $display("FAIL stall_refill got=%b exp=%b", obs_vec(), exp_vec());
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_cfg_err();
    do_cfg(1'b1, 2'd0, 4'b0000, 4'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (obs_vec() !== exp_vec() || cfg_err !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL err_stuck%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    do_cfg(1'b1, 2'd0, 4'b0001, 4'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 1'($urandom);
      tick();
      #1;
      tests++;
      if (obs_vec() !== exp_vec() || cfg_err !== 1'b0 || out_valid !== 4'b0001) begin
        fails++;
        $display("FAIL err_clear%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_cfg(1'b1, 2'd0, 4'b1111, 4'd1);
    in_valid = 1'b1; out_ready = 4'hf;
    tick();
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    tick();
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || m_ptr != 2 || out_valid !== 4'b0010) begin
      fails++;
      $display("FAIL mid_setup got=%b exp=%b", obs_vec(), exp_vec());
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || out_valid !== 4'b0000 || enable !== 1'b0 || sig !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset got=%b exp=%b", obs_vec(), exp_vec());
    end
    in_valid = 1'b1; out_ready = 4'hf; in_data = 1'b1;
    tick();
    #1;
    tests++;
    if (obs_vec() !== exp_vec() || out_valid !== 4'b0001 || sig !== 2'd0) begin
      fails++;
      $display("FAIL mid_first got=%b exp=%b", obs_vec(), exp_vec());
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 1'($urandom);
      out_ready = 4'($urandom);
      cfg_load  = ($urandom_range(0, 39) == 0);
      if (cfg_load && m_phase == 0) begin
        cfg_mode  = 1'($urandom);
        cfg_sel   = 2'($urandom);
        cfg_mask  = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
        cfg_burst = 4'($urandom_range(0, 4));
      end
      #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_burst2();
    test_rr_mask();
    test_backpressure();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
